// File: rtl/instruction_assembler_pkg.sv
// ---------------------------------------------------------------------------
// instruction_pkg : shared state type, defaults and operand-count decode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package instruction_pkg;

  typedef enum logic [1:0] {
    OPCODE  = 2'd0,
    OPERAND = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LEN_LSB    = 6;
  localparam int DEFAULT_LEN_WIDTH  = 2;

  function automatic int unsigned len_field_of(
    input logic [31:0] op,
    input int unsigned lsb   = DEFAULT_LEN_LSB,
    input int unsigned width = DEFAULT_LEN_WIDTH
  );
    return (op >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

  // Shared with the sequencer decoder so both agree on the clamp.
  function automatic int unsigned operand_count_of(
    input logic [31:0] op,
    input int unsigned max_ops = 2,
    input int unsigned lsb     = DEFAULT_LEN_LSB,
    input int unsigned width   = DEFAULT_LEN_WIDTH
  );
    int unsigned field;
    field = len_field_of(op, lsb, width);
    return (field > max_ops) ? max_ops : field;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_assembler_if.sv
// ---------------------------------------------------------------------------
// instruction_assembler_if : byte stream in, assembled instruction out
// Optional: INSTRUCTION_ASSEMBLER_ILLEGAL_EN adds the illegal flag. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface instruction_assembler_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_OPERANDS = 2
);
  localparam int CNT_W = $clog2(MAX_OPERANDS + 1);

  logic                               flush;
  logic                               byte_valid;
  logic                               byte_ready;
  logic [DATA_WIDTH-1:0]              byte_in;
  logic                               instr_valid;
  logic                               instr_ack;
  logic [DATA_WIDTH-1:0]              opcode;
  logic [MAX_OPERANDS*DATA_WIDTH-1:0] operand;
  logic [CNT_W-1:0]                   operand_count;
`ifdef INSTRUCTION_ASSEMBLER_ILLEGAL_EN
  logic                               illegal;

  modport master (
    output flush, byte_valid, byte_in, instr_ack,
    input  byte_ready, instr_valid, opcode, operand, operand_count, illegal
  );
  modport slave (
    input  flush, byte_valid, byte_in, instr_ack,
    output byte_ready, instr_valid, opcode, operand, operand_count, illegal
  );
`else
  modport master (
    output flush, byte_valid, byte_in, instr_ack,
    input  byte_ready, instr_valid, opcode, operand, operand_count
  );
  modport slave (
    input  flush, byte_valid, byte_in, instr_ack,
    output byte_ready, instr_valid, opcode, operand, operand_count
  );
`endif

endinterface

`default_nettype wire

// File: rtl/instruction_assembler.sv
// ---------------------------------------------------------------------------
// instruction_assembler : builds opcode + 0..MAX_OPERANDS operand instructions
// Optional: INSTRUCTION_ASSEMBLER_ILLEGAL_EN flags over-range length fields. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instruction_assembler
  import instruction_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int MAX_OPERANDS = 2,
  parameter int LEN_LSB      = DEFAULT_LEN_LSB,
  parameter int LEN_WIDTH    = DEFAULT_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_assembler_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_OPERANDS + 1);
  localparam int IDX_W = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;

  state_t                             r_state;
  state_t                             w_next_state;
  logic [IDX_W-1:0]                   r_index;
  logic [DATA_WIDTH-1:0]              r_opcode;
  logic [MAX_OPERANDS*DATA_WIDTH-1:0] r_operand;
  logic [CNT_W-1:0]                   r_operand_count;
  logic                               w_accept;
  logic                               w_last_operand;
  logic [CNT_W-1:0]                   w_count_in;

  assign w_accept       = bus.byte_valid && (r_state != FULL);
  assign w_count_in     = CNT_W'(operand_count_of(32'(bus.byte_in), MAX_OPERANDS,
                                                  LEN_LSB, LEN_WIDTH));
  assign w_last_operand = (32'(r_index) + 32'd1) == 32'(r_operand_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= OPCODE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.flush) begin
      w_next_state = OPCODE;
    end else begin
      case (r_state)
        OPCODE:  if (bus.byte_valid) w_next_state = (w_count_in == '0) ? FULL : OPERAND;
        OPERAND: if (bus.byte_valid && w_last_operand) w_next_state = FULL;
        FULL:    if (bus.instr_ack) w_next_state = OPCODE;
        default: w_next_state = OPCODE;
      endcase
    end
  end

  always_comb begin
    bus.byte_ready    = (r_state != FULL);
    bus.instr_valid   = (r_state == FULL);
    bus.opcode        = r_opcode;
    bus.operand       = r_operand;
    bus.operand_count = r_operand_count;
  end

  // Flush only rewinds the index; the last instruction stays visible on the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_index         <= '0;
      r_opcode        <= '0;
      r_operand       <= '0;
      r_operand_count <= '0;
    end else if (bus.flush) begin
      r_index <= '0;
    end else if (w_accept) begin
      if (r_state == OPCODE) begin
        r_opcode        <= bus.byte_in;
        r_operand       <= '0;
        r_index         <= '0;
        r_operand_count <= w_count_in;
      end else begin
        r_operand[r_index*DATA_WIDTH +: DATA_WIDTH] <= bus.byte_in;
        if (!w_last_operand) begin
          r_index <= r_index + 1'b1;
        end
      end
    end
  end

`ifdef INSTRUCTION_ASSEMBLER_ILLEGAL_EN
  logic r_illegal;
  logic w_field_illegal;

  assign w_field_illegal = len_field_of(32'(bus.byte_in), LEN_LSB, LEN_WIDTH)
                           > 32'(MAX_OPERANDS);
  assign bus.illegal     = r_illegal;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_illegal <= 1'b0;
    end else if (w_accept && (r_state == OPCODE)) begin
      r_illegal <= w_field_illegal;
    end
  end
`endif

endmodule

`default_nettype wire
